bp_update_ctrl: RTL and testbench

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_update_fifo.sv | 62 ++++++
 rtl/bp_update_ctrl.sv | 117 +++++++++++
 tb/tb_bp_update_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared defaults, FSM state encoding and update-entry record for
//            the branch-predictor update controller.
// Revision : 1.0
// ============================================================================
package bp_pkg;

  localparam int c_pc_bits  = 12;
  localparam int c_qdepth   = 4;
  localparam int c_cnt_bits = 16;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bp_state_t;

  // Entry layout used on the queue, MSB first: pc, target, taken.
  typedef struct packed {
    logic [c_pc_bits-1:0] pc;
    logic [c_pc_bits-1:0] target;
    logic                 taken;
  } bp_upd_t;

endpackage
`default_nettype wire

// File: rtl/bp_update_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_fifo
// Purpose  : Power-of-two FIFO holding pending predictor updates.
// Revision : 1.0
// ============================================================================
module bp_update_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_cnt = (c_aw+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full      = (r_count == c_full_cnt);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // Guarding here makes push-on-full and pop-on-empty no-ops.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_ctrl
// Purpose  : Resolves EX branches, raises redirects on mispredict and queues
//            predictor updates behind a valid/ready write port.
// Revision : 1.0
// ============================================================================
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int PC_BITS = c_pc_bits,
  parameter int QDEPTH  = c_qdepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EX_brn,
  input  logic [PC_BITS-1:0]    EX_pc,
  input  logic [PC_BITS-1:0]    EX_alu_out,
  input  logic                  EX_true_taken,
  input  logic                  EX_pred_taken,
  input  logic [PC_BITS-1:0]    EX_pred_target,
  input  logic                  MEM_stall,
  output logic                  EX_stall,
  output logic                  flush,
  output logic [PC_BITS-1:0]    redirect_pc,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [PC_BITS-1:0]    upd_pc,
  output logic [PC_BITS-1:0]    upd_target,
  output logic                  upd_taken,
  output logic [c_cnt_bits-1:0] mispred_cnt,
  output logic [c_cnt_bits-1:0] branch_cnt
);

  localparam int c_ew = 2*PC_BITS + 1;
  localparam int c_aw = $clog2(QDEPTH);
  localparam logic [c_aw:0] c_full_cnt = (c_aw+1)'(QDEPTH);

  bp_state_t             r_state;
  bp_state_t             w_state_next;
  logic [PC_BITS-1:0]    r_redirect;
  logic [c_cnt_bits-1:0] r_branch_cnt;
  logic [c_cnt_bits-1:0] r_mispred_cnt;
  logic                  w_accept;
  logic                  w_mispred;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_aw:0]         w_count;
  logic [c_ew-1:0]       w_head;

  assign EX_stall  = (w_count == c_full_cnt);
  assign w_accept  = EX_brn & ~MEM_stall & ~EX_stall & (r_state == NORMAL);
  assign w_mispred = w_accept & ((EX_pred_taken != EX_true_taken) |
                                 (EX_true_taken & (EX_pred_target != EX_alu_out)));
  assign w_push    = w_accept & ~w_full;
  assign w_pop     = upd_valid & upd_ready;

  bp_update_fifo #(
    .WIDTH (c_ew),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({EX_pc, EX_alu_out, EX_true_taken}),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign upd_valid = ~w_empty;
  assign {upd_pc, upd_target, upd_taken} = w_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= NORMAL;
    else      r_state <= w_state_next;
  end

  // RECOVER is the single flush cycle; wrong-path EX branches are dropped there.
  always_comb begin
    w_state_next = r_state;
    flush        = 1'b0;
    case (r_state)
      NORMAL:  if (w_mispred) w_state_next = RECOVER;
      RECOVER: begin
        flush        = 1'b1;
        w_state_next = NORMAL;
      end
      default: w_state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_redirect    <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_mispred)
        r_redirect <= EX_true_taken ? EX_alu_out : EX_pc + 1'b1;
      if (w_accept && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mispred && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign redirect_pc = r_redirect;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_ctrl
// Purpose  : Directed stimulus with queued expectations checked by a monitor.
// Revision : 1.0
// ============================================================================
module tb_bp_update_ctrl;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EX_brn = 1'b0;
  logic [11:0] EX_pc = '0;
  logic [11:0] EX_alu_out = '0;
  logic        EX_true_taken = 1'b0;
  logic        EX_pred_taken = 1'b0;
  logic [11:0] EX_pred_target = '0;
  logic        MEM_stall = 1'b0;
  logic        upd_ready = 1'b1;
  logic        EX_stall;
  logic        flush;
  logic [11:0] redirect_pc;
  logic        upd_valid;
  logic [11:0] upd_pc;
  logic [11:0] upd_target;
  logic        upd_taken;
  logic [15:0] mispred_cnt;
  logic [15:0] branch_cnt;

  bp_update_ctrl #(.PC_BITS(12), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_alu_out(EX_alu_out),
    .EX_true_taken(EX_true_taken), .EX_pred_taken(EX_pred_taken),
    .EX_pred_target(EX_pred_target), .MEM_stall(MEM_stall), .EX_stall(EX_stall),
    .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .mispred_cnt(mispred_cnt), .branch_cnt(branch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] pc;
    int          cyc;
  } redir_t;

  bp_upd_t exp_upd[$];
  int      upd_cyc[$];
  redir_t  exp_red[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every flush and every update handshake consumes one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (flush) begin
        if (exp_red.size() == 0) check("flush_unexpected", {31'd0, flush}, 32'd0);
        else begin
          redir_t r;
          r = exp_red.pop_front();
          check("redirect_pc", {20'd0, redirect_pc}, {20'd0, r.pc});
          check("flush_cycle", cyc, r.cyc);
        end
      end
      if (upd_valid && upd_ready) begin
        if (exp_upd.size() == 0) check("upd_unexpected", {31'd0, upd_valid}, 32'd0);
        else begin
          bp_upd_t e;
          int      c;
          e = exp_upd.pop_front();
          c = upd_cyc.pop_front();
          check("upd_pc",     {20'd0, upd_pc},     {20'd0, e.pc});
          check("upd_target", {20'd0, upd_target}, {20'd0, e.target});
          check("upd_taken",  {31'd0, upd_taken},  {31'd0, e.taken});
          check("upd_latency", {31'd0, (cyc > c)}, 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One EX cycle with a branch; acc/mp/redir are hand-computed expectations.
  task automatic issue(input logic [11:0] pc, input logic [11:0] alu, input logic tt,
                       input logic pt, input logic [11:0] ptgt,
                       input bit acc, input bit mp, input logic [11:0] redir);
    EX_brn = 1'b1; EX_pc = pc; EX_alu_out = alu;
    EX_true_taken = tt; EX_pred_taken = pt; EX_pred_target = ptgt;
    if (acc) begin
      exp_upd.push_back('{pc: pc, target: alu, taken: tt});
      upd_cyc.push_back(cyc);
    end
    if (mp) exp_red.push_back('{pc: redir, cyc: cyc + 1});
    tick();
    EX_brn = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_flush"},       {31'd0, flush},       32'd0);
    check({tag, "_ex_stall"},    {31'd0, EX_stall},    32'd0);
    check({tag, "_upd_valid"},   {31'd0, upd_valid},   32'd0);
    check({tag, "_redirect_pc"}, {20'd0, redirect_pc}, 32'd0);
    check({tag, "_branch_cnt"},  {16'd0, branch_cnt},  32'd0);
    check({tag, "_mispred_cnt"}, {16'd0, mispred_cnt}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    tick();

    // Correct not-taken
    check("pre_upd_valid", {31'd0, upd_valid}, 32'd0);
    issue(12'h010, 12'h011, 1'b0, 1'b0, 12'h000, 1, 0, 12'h000);
    check("nt_flush",      {31'd0, flush},      32'd0);
    check("nt_upd_valid",  {31'd0, upd_valid},  32'd1);
    check("nt_branch_cnt", {16'd0, branch_cnt}, 32'd1);
    check("nt_mp_cnt",     {16'd0, mispred_cnt}, 32'd0);
    tick();
    check("nt_drained", {31'd0, upd_valid}, 32'd0);

    // Direction mispredict, then a wrong-path branch during RECOVER
    issue(12'h020, 12'h080, 1'b1, 1'b0, 12'h000, 1, 1, 12'h080);
    check("dir_flush", {31'd0, flush}, 32'd1);
    issue(12'h030, 12'h031, 1'b0, 1'b0, 12'h000, 0, 0, 12'h000);
    check("dir_flush_one_cycle", {31'd0, flush},      32'd0);
    check("dir_branch_cnt",      {16'd0, branch_cnt}, 32'd2);
    check("dir_mp_cnt",          {16'd0, mispred_cnt}, 32'd1);

    // Target mispredict, correct taken, predicted-taken-but-not-taken
    issue(12'h040, 12'h120, 1'b1, 1'b1, 12'h100, 1, 1, 12'h120);
    tick();
    issue(12'h050, 12'h200, 1'b1, 1'b1, 12'h200, 1, 0, 12'h000);
    issue(12'h060, 12'h0AA, 1'b0, 1'b1, 12'h300, 1, 1, 12'h061);
    tick();

    // MEM_stall blocks accept
    MEM_stall = 1'b1;
    issue(12'h070, 12'h444, 1'b1, 1'b0, 12'h000, 0, 0, 12'h000);
    MEM_stall = 1'b0;

    // PC wrap on not-taken redirect
    issue(12'hFFF, 12'h123, 1'b0, 1'b1, 12'h500, 1, 1, 12'h000);
    tick();
    check("mid_branch_cnt", {16'd0, branch_cnt},  32'd6);
    check("mid_mp_cnt",     {16'd0, mispred_cnt}, 32'd4);

    // Back-to-back accepts with simultaneous push/pop
    for (int i = 0; i < 3; i++)
      issue(12'h0A0 + 12'(i), 12'h0B0 + 12'(i), 1'b0, 1'b0, 12'h000, 1, 0, 12'h000);
    tick();
    tick();
    check("b2b_drained", {31'd0, upd_valid}, 32'd0);

    // Fill the queue with the write port blocked
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill_no_stall", {31'd0, EX_stall}, 32'd0);
      issue(12'h100 + 12'(i), 12'h180 + 12'(i), 1'b0, 1'b0, 12'h000, 1, 0, 12'h000);
    end
    check("full_stall", {31'd0, EX_stall}, 32'd1);
    issue(12'h104, 12'h184, 1'b0, 1'b0, 12'h000, 0, 0, 12'h000);
    check("full_stall_hold", {31'd0, EX_stall},   32'd1);
    check("full_branch_cnt", {16'd0, branch_cnt}, 32'd13);
    upd_ready = 1'b1;
    tick();
    check("stall_drop", {31'd0, EX_stall}, 32'd0);
    for (int i = 0; i < 10 && upd_valid; i++) tick();
    check("drain_timeout", {31'd0, upd_valid}, 32'd0);

    // Async reset mid-flush with three entries queued
    upd_ready = 1'b0;
    issue(12'h200, 12'h201, 1'b0, 1'b0, 12'h000, 1, 0, 12'h000);
    issue(12'h202, 12'h203, 1'b0, 1'b0, 12'h000, 1, 0, 12'h000);
    issue(12'h210, 12'h250, 1'b1, 1'b0, 12'h000, 1, 1, 12'h250);
    check("pre_reset_flush", {31'd0, flush},     32'd1);
    check("pre_reset_valid", {31'd0, upd_valid}, 32'd1);
    #2;
    rst = 1'b0;
    exp_upd.delete();
    upd_cyc.delete();
    exp_red.delete();
    #1;
    check_idle("async");
    tick();
    rst = 1'b1;
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_valid", {31'd0, upd_valid}, 32'd0);
    end
    check_idle("post_reset");

    check("upd_leftover", exp_upd.size(), 32'd0);
    check("redir_leftover", exp_red.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
